dp_ram_resp: RTL and testbench

DP_RAM_RESP -- requirements
Module: dp_ram_resp

---
 rtl/dp_ram_resp_if.sv | 25 ++
 rtl/dp_ram_resp.sv | 90 +++++++++
 tb/tb_dp_ram_resp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_resp_if.sv
// Request/response bundle for dp_ram_resp: write port, read port, registered
// read response and the init_done status flag.
interface dp_ram_resp_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  wr_enb;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_enb;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_done;

   modport master (
      output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
      input  rd_data, rd_valid, init_done
   );

   modport slave (
      input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
      output rd_data, rd_valid, init_done
   );
endinterface

// File: rtl/dp_ram_resp.sv
// Dual-port RAM with a post-reset clear sweep and a registered, 1-cycle read response.
// Macro RAM_WR_BYPASS_EN: same-address read-during-write returns the new data (write-first).
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | clearing one word per cycle, requests ignored, init_done = 0
// RUN   | normal operation, requests accepted, init_done = 1
module dp_ram_resp #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   dp_ram_resp_if.slave     bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH:0]   clr_cnt, clr_cnt_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  wr_accept;
   logic                  rd_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         INIT: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
               state_nxt   = RUN;
               clr_cnt_nxt = '0;
            end
         end
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   assign wr_accept = (state == RUN) && bus.wr_enb;
   assign rd_accept = (state == RUN) && bus.rd_enb;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT)
            mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
         else if (wr_accept)
            mem[bus.wr_addr] <= bus.wr_data;
      end
   end

`ifdef RAM_WR_BYPASS_EN
   assign rd_word = (wr_accept && (bus.wr_addr == bus.rd_addr)) ? bus.wr_data
                                                                : mem[bus.rd_addr];
`else
   // Array read in the same edge as the write sees the old contents.
   assign rd_word = mem[bus.rd_addr];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept)
            rd_data_q <= rd_word;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.init_done = (state == RUN);
endmodule

// File: tb/tb_dp_ram_resp.sv
// Directed bench for dp_ram_resp: clear sweep timing, request masking in INIT,
// read latency/holding, same-address read-during-write and reset mid-operation.
module tb_dp_ram_resp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   dp_ram_resp_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

   dp_ram_resp #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.wr_enb = 1'b0;
      bus.rd_enb = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus.wr_enb  = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
   endtask

   task automatic rd(input logic [3:0] a);
      bus.rd_enb  = 1'b1;
      bus.rd_addr = a;
   endtask

   // rst must already be low; counts edges until init_done rises
   task automatic count_init(output int n, output logic saw_valid);
      n = 0;
      saw_valid = 1'b0;
      while (n < 64) begin
         step();
         n++;
         if (bus.rd_valid) saw_valid = 1'b1;
         if (bus.init_done) break;
      end
   endtask

   logic [7:0] exp_byp;
   int         n_init;
   logic       saw_v;

   initial begin
`ifdef RAM_WR_BYPASS_EN
      exp_byp = 8'h3C;
`else
      exp_byp = 8'h11;
`endif
      idle();
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      @(negedge clk);
      step();
      step();
      chk("reset_init_done", 32'(bus.init_done), 0);
      chk("reset_rd_valid", 32'(bus.rd_valid), 0);
      chk("reset_rd_data", 32'(bus.rd_data), 0);

      // requests held active for the whole sweep must be ignored
      rst = 1'b0;
      wr(4'd2, 8'hFF);
      rd(4'd2);
      count_init(n_init, saw_v);
      chk("init_len", n_init, 16);
      chk("init_no_rd_valid", 32'(saw_v), 0);
      idle();

      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         step();
         chk($sformatf("clear_valid_%0d", i), 32'(bus.rd_valid), 1);
         chk($sformatf("clear_data_%0d", i), 32'(bus.rd_data), 0);
      end
      idle();
      step();
      chk("idle_no_valid", 32'(bus.rd_valid), 0);

      wr(4'd3, 8'hA5);
      step();
      idle();
      rd(4'd3);
      step();
      idle();
      chk("rd3_valid", 32'(bus.rd_valid), 1);
      chk("rd3_data", 32'(bus.rd_data), 32'hA5);
      step();
      chk("hold_valid", 32'(bus.rd_valid), 0);
      chk("hold_data", 32'(bus.rd_data), 32'hA5);
      rd(4'd4);
      step();
      idle();
      chk("rd4_data", 32'(bus.rd_data), 0);

      wr(4'd7, 8'h11);
      step();
      wr(4'd7, 8'h3C);
      rd(4'd7);
      step();
      idle();
      chk("rdw_same_valid", 32'(bus.rd_valid), 1);
      chk("rdw_same_data", 32'(bus.rd_data), 32'(exp_byp));
      rd(4'd7);
      step();
      idle();
      chk("rd7_after", 32'(bus.rd_data), 32'h3C);

      wr(4'd5, 8'h77);
      rd(4'd3);
      step();
      idle();
      chk("rdw_diff_data", 32'(bus.rd_data), 32'hA5);
      rd(4'd5);
      step();
      idle();
      chk("rd5_data", 32'(bus.rd_data), 32'h77);

      wr(4'd0, 8'h10); step();
      wr(4'd1, 8'h20); step();
      wr(4'd2, 8'h30); step();
      idle();
      for (int i = 0; i < 3; i++) begin
         rd(4'(i));
         step();
         chk($sformatf("b2b_valid_%0d", i), 32'(bus.rd_valid), 1);
         chk($sformatf("b2b_data_%0d", i), 32'(bus.rd_data), 32'((i + 1) * 16));
      end
      idle();
      step();
      chk("b2b_end_valid", 32'(bus.rd_valid), 0);
      chk("b2b_end_data", 32'(bus.rd_data), 32'h30);

      // reset with a read and a write on the same edge
      wr(4'd9, 8'h55);
      step();
      rd(4'd9);
      wr(4'd10, 8'hEE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("rst_drop_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_init_done", 32'(bus.init_done), 0);
      count_init(n_init, saw_v);
      chk("reinit_len", n_init, 16);
      chk("reinit_no_valid", 32'(saw_v), 0);
      rd(4'd9);
      step();
      rd(4'd10);
      chk("rd9_cleared", 32'(bus.rd_data), 0);
      chk("rd9_valid", 32'(bus.rd_valid), 1);
      step();
      idle();
      chk("rd10_cleared", 32'(bus.rd_data), 0);

      // reset part-way through the sweep restarts it from address 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("mid_init_done", 32'(bus.init_done), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      count_init(n_init, saw_v);
      chk("mid_reinit_len", n_init, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
